gpio_port: RTL and testbench
============================

# gpio_port

Parametrised memory-mapped GPIO port with up to 32 pins, replacing the fixed 8-bit port on the peripheral bus. It provides:
- atomic set/clear/toggle output registers and per-pin direction control;
- a two-flop input synchronizer;
- per-pin rising/falling edge detection with sticky flags and one level interrupt to the core's interrupt line.

Pad buffers are instantiated at the top level from `port_out`/`port_oe`/`port_in`.

## Interface
- `WIDTH`, default 8: number of pins, legal range 1..32. Register bits at and above `WIDTH` read 0 and ignore writes.
- `clk` input 1: clock.
- `nreset` input 1: reset, asynchronous, active-low. Clock is `clk`.
- `clken` input 1: bus access strobe. One access per cycle when high.
- `rw` input 1: 1 = read, 0 = write. Sampled with `clken`.
- `addr` input 4: word register index.
- `byte_en` input 4: write byte lanes. Lane k covers `wdata[8k+7:8k]`.
- `wdata` input 32: write data.
- `rdata` output 32: registered read data.
- `port_in` input WIDTH: raw pad inputs, asynchronous.
- `port_out` output WIDTH: pad output values (= PDOR).
- `port_oe` output WIDTH: pad output enables (= PDDR; 1 = drive).
- `irq` output 1: OR of (PIFR), level, active-high.

## Operation
- Register map (addr, access):
  - 0 PDOR RW: output data.
  - 1 PSOR W: PDOR |= wdata.
  - 2 PCOR W: PDOR &= ~wdata.
  - 3 PTOR W: PDOR ^= wdata.
  - 4 PDIR R: synchronized pin state. Reflects the pad even when driven.
  - 5 PDDR RW: direction.
  - 6 PRER RW: rising-edge enable.
  - 7 PFER RW: falling-edge enable.
  - 8 PIFR R/W1C: edge flags.
  - 9..15: unmapped.
- Write = `clken & ~rw`.
  - The effective mask is the byte_en lanes expanded to bits, AND bits below `WIDTH`.
  - Bits outside the mask are unchanged for every register, including PSOR/PCOR/PTOR/PIFR operations.
- PSOR/PCOR/PTOR hold no state. Reads of them, and of unmapped addresses, return 0. Writes to PDIR and to unmapped addresses are ignored.
- Read = `clken & rw`: `rdata` <= selected register, zero-extended to 32 bits. `rdata` holds its value when there is no read.
- Synchronizer: sync1 <= `port_in`, sync2 <= sync1 (sync2 = PDIR), prev <= sync2.
- Edge detection:
  - rise = sync2 & ~prev & PRER.
  - fall = ~sync2 & prev & PFER.
- PIFR next = (PIFR & ~(W1C mask & wdata when writing addr 8)) | rise | fall.
  - Set wins over a simultaneous W1C on the same bit.
- Disabling PRER/PFER does not clear flags that are already set.

## Timing
- Reset (async): PDOR, PDDR, PRER, PFER, PIFR, sync1, sync2, prev, `rdata` = 0. Therefore `port_oe` = 0 (all inputs), `port_out` = 0, `irq` = 0.
- Release of reset is synchronous to `clk` at the top level.
- Register writes take effect at the sampling edge. `port_out`/`port_oe` change in the same cycle as the register, with no extra stage.
- Read latency is 1 cycle: `rdata` is valid after the edge that samples `clken & rw`.
- Back-to-back write-then-read of the same register returns the new value.
- Pin change captured at edge N:
  - PDIR shows it after edge N+1.
  - PIFR bit and `irq` go high after edge N+2.
- Pulses shorter than one clock period may be missed; this is by design.
- `irq` is combinational from PIFR flops only, with no bus-input path.
- Reset mid-operation clears all flags and drops `irq` and the output enables immediately.

## Test plan
- Reset with `WIDTH`=8 -> all reads return 0, `port_oe`=0x00, `irq`=0. Then write PDDR=0xFF, byte_en=0001 -> `port_oe`=0xFF.
- PDOR=0xF0, then PSOR 0x03 -> 0xF3, then PCOR 0x30 -> 0xC3, then PTOR 0xFF -> 0x3C. `port_out` matches after each write, and reads of PSOR/PCOR/PTOR return 0.
- `WIDTH`=12: write PDOR 0xFFFF_FFFF with byte_en=0010 -> PDOR=0xF00. With byte_en=1111 -> read returns 0x0000_0FFF.
- PRER bit 2 = 1, drive `port_in[2]` 0->1 at edge N -> PDIR bit 2 = 1 after N+1, PIFR=0x04 and `irq`=1 after N+2. Falling edge with PFER=0 -> no new flag.
- W1C: PIFR=0x05, write 0x01 -> PIFR=0x04, `irq` stays 1. Write 0x04 in the same cycle a new enabled edge sets bit 2 -> bit 2 stays 1.
- Assert `nreset` while PIFR≠0 and PDDR≠0 -> `irq` and `port_oe` go 0 asynchronously. No flag appears after release with a static pin.

Source files
------------

// File: rtl/gpio_port.sv
// rtl/gpio_port.sv - parametrised memory-mapped GPIO port with edge-detect interrupt
module gpio_port #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             clken,
  input  logic             rw,
  input  logic [3:0]       addr,
  input  logic [3:0]       byte_en,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] port_in,
  output logic [WIDTH-1:0] port_out,
  output logic [WIDTH-1:0] port_oe,
  output logic             irq
);

  localparam logic [3:0] A_PDOR = 4'd0;
  localparam logic [3:0] A_PSOR = 4'd1;
  localparam logic [3:0] A_PCOR = 4'd2;
  localparam logic [3:0] A_PTOR = 4'd3;
  localparam logic [3:0] A_PDIR = 4'd4;
  localparam logic [3:0] A_PDDR = 4'd5;
  localparam logic [3:0] A_PRER = 4'd6;
  localparam logic [3:0] A_PFER = 4'd7;
  localparam logic [3:0] A_PIFR = 4'd8;

  logic [WIDTH-1:0] r_pdor;
  logic [WIDTH-1:0] r_pddr;
  logic [WIDTH-1:0] r_prer;
  logic [WIDTH-1:0] r_pfer;
  logic [WIDTH-1:0] r_pifr;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;

  logic             w_wr;
  logic             w_rd;
  logic [31:0]      w_lane_mask;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_bits;
  logic [WIDTH-1:0] w_pdor_next;
  logic [WIDTH-1:0] w_pifr_clr;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_rsel;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_wr        = clken & ~rw;
  assign w_rd        = clken & rw;
  assign w_lane_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
  // Lanes beyond WIDTH simply drop out here, so upper register bits never exist.
  assign w_mask      = w_lane_mask[WIDTH-1:0];
  assign w_bits      = wdata[WIDTH-1:0] & w_mask;
  assign w_unused    = ^{wdata, w_lane_mask};

  assign w_rise      = r_sync2 & ~r_prev & r_prer;
  assign w_fall      = ~r_sync2 & r_prev & r_pfer;
  assign w_pifr_clr  = (w_wr && addr == A_PIFR) ? w_bits : '0;

  assign port_out    = r_pdor;
  assign port_oe     = r_pddr;
  assign irq         = |r_pifr;

  // Output data update: plain write plus the atomic set/clear/toggle aliases.
  always_comb begin
    w_pdor_next = r_pdor;
    if (w_wr) begin
      case (addr)
        A_PDOR:  w_pdor_next = (r_pdor & ~w_mask) | w_bits;
        A_PSOR:  w_pdor_next = r_pdor | w_bits;
        A_PCOR:  w_pdor_next = r_pdor & ~w_bits;
        A_PTOR:  w_pdor_next = r_pdor ^ w_bits;
        default: w_pdor_next = r_pdor;
      endcase
    end
  end

  // Read mux; alias, write-only and unmapped addresses return zero.
  always_comb begin
    w_rsel = '0;
    case (addr)
      A_PDOR:  w_rsel = r_pdor;
      A_PDIR:  w_rsel = r_sync2;
      A_PDDR:  w_rsel = r_pddr;
      A_PRER:  w_rsel = r_prer;
      A_PFER:  w_rsel = r_pfer;
      A_PIFR:  w_rsel = r_pifr;
      default: w_rsel = '0;
    endcase
    w_rdata = 32'(w_rsel);
  end

  // Control registers and registered read data.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_pdor <= '0;
      r_pddr <= '0;
      r_prer <= '0;
      r_pfer <= '0;
      rdata  <= '0;
    end else begin
      r_pdor <= w_pdor_next;
      if (w_wr && addr == A_PDDR) r_pddr <= (r_pddr & ~w_mask) | w_bits;
      if (w_wr && addr == A_PRER) r_prer <= (r_prer & ~w_mask) | w_bits;
      if (w_wr && addr == A_PFER) r_pfer <= (r_pfer & ~w_mask) | w_bits;
      if (w_rd) rdata <= w_rdata;
    end
  end

  // Two-flop synchronizer, previous-sample stage and sticky edge flags (set beats W1C).
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_pifr  <= '0;
    end else begin
      r_sync1 <= port_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pifr  <= (r_pifr & ~w_pifr_clr) | w_rise | w_fall;
    end
  end

endmodule

// File: tb/tb_gpio_port.sv
// tb/tb_gpio_port.sv - directed self-checking bench for gpio_port
module tb_gpio_port;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        clken8 = 1'b0;
  logic        clken12 = 1'b0;
  logic        rw = 1'b0;
  logic [3:0]  addr = '0;
  logic [3:0]  byte_en = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata8;
  logic [31:0] rdata12;
  logic [7:0]  port_in8 = '0;
  logic [7:0]  port_out8;
  logic [7:0]  port_oe8;
  logic        irq8;
  logic [11:0] port_in12 = '0;
  logic [11:0] port_out12;
  logic [11:0] port_oe12;
  logic        irq12;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] v;

  always #5 clk = ~clk;

  gpio_port #(.WIDTH(8)) u_dut8 (
    .clk(clk), .nreset(nreset), .clken(clken8), .rw(rw), .addr(addr),
    .byte_en(byte_en), .wdata(wdata), .rdata(rdata8), .port_in(port_in8),
    .port_out(port_out8), .port_oe(port_oe8), .irq(irq8)
  );

  gpio_port #(.WIDTH(12)) u_dut12 (
    .clk(clk), .nreset(nreset), .clken(clken12), .rw(rw), .addr(addr),
    .byte_en(byte_en), .wdata(wdata), .rdata(rdata12), .port_in(port_in12),
    .port_out(port_out12), .port_oe(port_oe12), .irq(irq12)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel12, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    clken8 = !sel12; clken12 = sel12; rw = 1'b0; addr = a; wdata = d; byte_en = be;
    tick();
    clken8 = 1'b0; clken12 = 1'b0;
  endtask

  task automatic rd(input bit sel12, input logic [3:0] a, output logic [31:0] d);
    clken8 = !sel12; clken12 = sel12; rw = 1'b1; addr = a;
    tick();
    clken8 = 1'b0; clken12 = 1'b0; rw = 1'b0;
    d = sel12 ? rdata12 : rdata8;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    tick();

    chk("reset_rdata", rdata8, 32'h0);
    chk("reset_oe", {24'h0, port_oe8}, 32'h0);
    chk("reset_out", {24'h0, port_out8}, 32'h0);
    chk("reset_irq", {31'h0, irq8}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      rd(1'b0, 4'(i), v);
      chk($sformatf("reset_read_a%0d", i), v, 32'h0);
    end

    wr(1'b0, 4'd5, 32'h0000_00FF, 4'b0001);
    chk("pddr_oe", {24'h0, port_oe8}, 32'h0000_00FF);

    wr(1'b0, 4'd0, 32'h0000_00F0, 4'b0001);
    chk("pdor_out", {24'h0, port_out8}, 32'h0000_00F0);
    wr(1'b0, 4'd1, 32'h0000_0003, 4'b0001);
    chk("psor_out", {24'h0, port_out8}, 32'h0000_00F3);
    rd(1'b0, 4'd1, v);
    chk("psor_read", v, 32'h0);
    wr(1'b0, 4'd2, 32'h0000_0030, 4'b0001);
    chk("pcor_out", {24'h0, port_out8}, 32'h0000_00C3);
    rd(1'b0, 4'd2, v);
    chk("pcor_read", v, 32'h0);
    wr(1'b0, 4'd3, 32'h0000_00FF, 4'b0001);
    chk("ptor_out", {24'h0, port_out8}, 32'h0000_003C);
    rd(1'b0, 4'd3, v);
    chk("ptor_read", v, 32'h0);
    rd(1'b0, 4'd0, v);
    chk("pdor_read", v, 32'h0000_003C);
    wr(1'b0, 4'd0, 32'h0000_00FF, 4'b0010);
    chk("pdor_lane_masked", {24'h0, port_out8}, 32'h0000_003C);
    wr(1'b0, 4'd4, 32'h0000_00FF, 4'b1111);
    rd(1'b0, 4'd4, v);
    chk("pdir_write_ignored", v, 32'h0);

    wr(1'b1, 4'd0, 32'hFFFF_FFFF, 4'b0010);
    chk("w12_out_lane1", {20'h0, port_out12}, 32'h0000_0F00);
    rd(1'b1, 4'd0, v);
    chk("w12_read_lane1", v, 32'h0000_0F00);
    wr(1'b1, 4'd0, 32'hFFFF_FFFF, 4'b1111);
    rd(1'b1, 4'd0, v);
    chk("w12_read_all", v, 32'h0000_0FFF);
    chk("w12_no_crosstalk", {24'h0, port_out8}, 32'h0000_003C);

    wr(1'b0, 4'd6, 32'h0000_0004, 4'b0001);
    port_in8 = 8'h04;
    tick();
    chk("edge_irq_n", {31'h0, irq8}, 32'h0);
    rd(1'b0, 4'd4, v);
    chk("edge_pdir_n1", v, 32'h0);
    chk("edge_irq_n1", {31'h0, irq8}, 32'h0);
    rd(1'b0, 4'd4, v);
    chk("edge_pdir_n2", v, 32'h0000_0004);
    chk("edge_irq_n2", {31'h0, irq8}, 32'h1);
    rd(1'b0, 4'd8, v);
    chk("edge_pifr", v, 32'h0000_0004);

    port_in8 = 8'h00;
    repeat (4) tick();
    rd(1'b0, 4'd8, v);
    chk("fall_disabled", v, 32'h0000_0004);

    wr(1'b0, 4'd6, 32'h0000_0005, 4'b0001);
    port_in8 = 8'h01;
    repeat (3) tick();
    rd(1'b0, 4'd8, v);
    chk("pifr_two_flags", v, 32'h0000_0005);
    wr(1'b0, 4'd8, 32'h0000_0001, 4'b0001);
    rd(1'b0, 4'd8, v);
    chk("w1c_bit0", v, 32'h0000_0004);
    chk("w1c_irq_stays", {31'h0, irq8}, 32'h1);
    wr(1'b0, 4'd8, 32'h0000_0004, 4'b0001);
    rd(1'b0, 4'd8, v);
    chk("w1c_bit2", v, 32'h0);
    chk("w1c_irq_drops", {31'h0, irq8}, 32'h0);
    wr(1'b0, 4'd8, 32'h0000_00FF, 4'b0000);
    chk("w1c_no_lane", {31'h0, irq8}, 32'h0);

    port_in8 = 8'h05;
    tick();
    tick();
    wr(1'b0, 4'd8, 32'h0000_0004, 4'b0001);
    rd(1'b0, 4'd8, v);
    chk("set_beats_w1c", v, 32'h0000_0004);

    wr(1'b0, 4'd6, 32'h0000_0000, 4'b0001);
    rd(1'b0, 4'd8, v);
    chk("prer_off_keeps_flag", v, 32'h0000_0004);

    wr(1'b0, 4'd7, 32'h0000_0001, 4'b0001);
    port_in8 = 8'h04;
    repeat (3) tick();
    rd(1'b0, 4'd8, v);
    chk("fall_enabled", v, 32'h0000_0005);

    chk("pre_reset_irq", {31'h0, irq8}, 32'h1);
    chk("pre_reset_oe", {24'h0, port_oe8}, 32'h0000_00FF);
    nreset = 1'b0;
    #2;
    chk("async_reset_irq", {31'h0, irq8}, 32'h0);
    chk("async_reset_oe", {24'h0, port_oe8}, 32'h0);
    chk("async_reset_out12", {20'h0, port_out12}, 32'h0);
    @(negedge clk);
    nreset = 1'b1;
    repeat (5) tick();
    chk("post_reset_irq", {31'h0, irq8}, 32'h0);
    rd(1'b0, 4'd8, v);
    chk("post_reset_pifr", v, 32'h0);
    rd(1'b0, 4'd4, v);
    chk("post_reset_pdir", v, 32'h0000_0004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
